legal_move_enumerator: RTL and testbench

//  Sequential producer of move requests for the combinational move verifier (Complete_Move_Verifier, external).
//  - On start, latches a 768-bit position, side to move and en-passant mask.
//  - Walks every (from, to) square pair and presents each to the verifier.
//  - Streams each pair the verifier accepts out over a valid/ready interface; pulses done with the legal-move count.
//  - Sits between search/UI control and the verifier; it is the request-generating end of that interface.

---
 rtl/legal_move_enumerator.sv | 143 ++++++++++++++
 tb/tb_legal_move_enumerator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legal_move_enumerator.sv
// Walks every (from, to) square pair of a latched position through an external
// move verifier and streams the accepted pairs out over a valid/ready handshake.
module legal_move_enumerator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             side,
  input  logic [767:0]     position,
  input  logic [63:0]      en_passant,
  output logic [2:0]       mv_from_x,
  output logic [2:0]       mv_from_y,
  output logic [2:0]       mv_to_x,
  output logic [2:0]       mv_to_y,
  output logic             mv_promo,
  output logic             mv_side,
  output logic [767:0]     mv_position,
  output logic [63:0]      mv_en_passant,
  input  logic             mv_is_valid,
  input  logic [3:0]       mv_piece,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_from,
  output logic [5:0]       out_to,
  output logic [3:0]       out_piece,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [2:0] {IDLE, SCAN_FROM, SCAN_TO, EMIT, FINISH} state_t;

  state_t         state, state_next;
  logic [5:0]     from_idx, to_idx;
  logic           side_q;
  logic [767:0]   pos_q;
  logic [63:0]    ep_q;
  logic [63:0]    own_mask;
  logic           from_own;
  state_t         adv_state;

  always_comb begin
    own_mask = '0;
    for (int k = 0; k < 6; k++)
      own_mask |= side_q ? pos_q[64*k +: 64] : pos_q[64*(k+6) +: 64];
  end

  assign from_own = own_mask[from_idx];

  // Where the scan goes once the current (from, to) pair is finished with.
  always_comb begin
    if (to_idx != 6'd63)        adv_state = SCAN_TO;
    else if (from_idx != 6'd63) adv_state = SCAN_FROM;
    else                        adv_state = FINISH;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks use blocking with a default first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) state_next = IDLE;
    else begin
      unique case (state)
        IDLE:      if (start) state_next = SCAN_FROM;
        SCAN_FROM: begin
          if (from_own)               state_next = SCAN_TO;
          else if (from_idx == 6'd63) state_next = FINISH;
        end
        SCAN_TO:   state_next = mv_is_valid ? EMIT : adv_state;
        EMIT:      if (out_ready) state_next = adv_state;
        FINISH:    state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      from_idx   <= '0;
      to_idx     <= '0;
      side_q     <= 1'b0;
      pos_q      <= '0;
      ep_q       <= '0;
      out_from   <= '0;
      out_to     <= '0;
      out_piece  <= '0;
      move_count <= '0;
    end else if (!abort) begin
      unique case (state)
        IDLE: if (start) begin
          side_q     <= side;
          pos_q      <= position;
          ep_q       <= en_passant;
          from_idx   <= '0;
          to_idx     <= '0;
          move_count <= '0;
        end
        SCAN_FROM: begin
          if (from_own)               to_idx   <= '0;
          else if (from_idx != 6'd63) from_idx <= from_idx + 6'd1;
        end
        SCAN_TO: begin
          if (mv_is_valid) begin
            out_from  <= from_idx;
            out_to    <= to_idx;
            out_piece <= mv_piece;
          end else begin
            to_idx <= to_idx + 6'd1;
            if (to_idx == 6'd63 && from_idx != 6'd63) from_idx <= from_idx + 6'd1;
          end
        end
        EMIT: if (out_ready) begin
          move_count <= move_count + CNT_W'(1);
          to_idx     <= to_idx + 6'd1;
          if (to_idx == 6'd63 && from_idx != 6'd63) from_idx <= from_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == FINISH);
    out_valid     = (state == EMIT);
    mv_from_x     = from_idx[2:0];
    mv_from_y     = from_idx[5:3];
    mv_to_x       = to_idx[2:0];
    mv_to_y       = to_idx[5:3];
    mv_promo      = 1'b0;
    mv_side       = side_q;
    mv_position   = pos_q;
    mv_en_passant = ep_q;
  end

endmodule

// File: tb/tb_legal_move_enumerator.sv
// Directed bench for legal_move_enumerator with a small behavioural move
// verifier (pawns, knights, kings) standing in for the external one.
module tb_legal_move_enumerator;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, side, out_ready;
  logic [767:0] position;
  logic [63:0]  en_passant;
  logic [2:0]   mv_from_x, mv_from_y, mv_to_x, mv_to_y;
  logic         mv_promo, mv_side, mv_is_valid;
  logic [767:0] mv_position;
  logic [63:0]  mv_en_passant;
  logic [3:0]   mv_piece, out_piece;
  logic         out_valid, busy, done;
  logic [5:0]   out_from, out_to;
  logic [7:0]   move_count;

  int checks = 0;
  int errors = 0;
  int dones;
  int cyc;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  legal_move_enumerator #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .side(side),
    .position(position), .en_passant(en_passant),
    .mv_from_x(mv_from_x), .mv_from_y(mv_from_y), .mv_to_x(mv_to_x), .mv_to_y(mv_to_y),
    .mv_promo(mv_promo), .mv_side(mv_side), .mv_position(mv_position),
    .mv_en_passant(mv_en_passant), .mv_is_valid(mv_is_valid), .mv_piece(mv_piece),
    .out_valid(out_valid), .out_ready(out_ready), .out_from(out_from), .out_to(out_to),
    .out_piece(out_piece), .busy(busy), .done(done), .move_count(move_count)
  );

  // Sliding pieces are not modelled; they have no moves in these positions.
  function automatic logic [4:0] verify(input logic [767:0] pos, input logic s,
                                        input logic [63:0] ep, input logic [5:0] f,
                                        input logic [5:0] t);
    logic [63:0] own, opp, occ;
    int k, fi, fy, dx, dy, adx, ady, dir, home;
    logic ok;
    own = '0; opp = '0; k = -1; ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      own |= pos[64*(s ? i : i+6) +: 64];
      opp |= pos[64*(s ? i+6 : i) +: 64];
      if (pos[64*(s ? i : i+6) + int'(f)]) k = i;
    end
    occ  = own | opp;
    fi   = int'(f);
    fy   = int'(f[5:3]);
    dx   = int'(t[2:0]) - int'(f[2:0]);
    dy   = int'(t[5:3]) - fy;
    adx  = (dx < 0) ? -dx : dx;
    ady  = (dy < 0) ? -dy : dy;
    dir  = s ? 1 : -1;
    home = s ? 1 : 6;
    if (k >= 0 && !own[t]) begin
      case (k)
        0: ok = (dx == 0 && dy == dir && !occ[t]) ||
                (dx == 0 && dy == 2*dir && fy == home && !occ[t] && !occ[fi + 8*dir]) ||
                (adx == 1 && dy == dir && (opp[t] || ep[t]));
        1: ok = (adx * ady == 2);
        5: ok = (adx <= 1 && ady <= 1 && (adx + ady) > 0);
        default: ok = 1'b0;
      endcase
    end
    return {ok, ok ? 4'(s ? k : k + 6) : 4'd0};
  endfunction

  always_comb {mv_is_valid, mv_piece} =
    verify(mv_position, mv_side, mv_en_passant, {mv_from_y, mv_from_x}, {mv_to_y, mv_to_x});

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_start_position();
    position = '0;
    position[0   +: 64] = 64'h0000_0000_0000_FF00;
    position[64  +: 64] = 64'h0000_0000_0000_0042;
    position[128 +: 64] = 64'h0000_0000_0000_0024;
    position[192 +: 64] = 64'h0000_0000_0000_0081;
    position[256 +: 64] = 64'h0000_0000_0000_0008;
    position[320 +: 64] = 64'h0000_0000_0000_0010;
    position[384 +: 64] = 64'h00FF_0000_0000_0000;
    position[448 +: 64] = 64'h4200_0000_0000_0000;
    position[512 +: 64] = 64'h2400_0000_0000_0000;
    position[576 +: 64] = 64'h8100_0000_0000_0000;
    position[640 +: 64] = 64'h0800_0000_0000_0000;
    position[704 +: 64] = 64'h1000_0000_0000_0000;
  endtask

  task automatic set_kings_only();
    position = '0;
    position[320 +: 64] = 64'h0000_0000_0000_0010;
    position[704 +: 64] = 64'h1000_0000_0000_0000;
  endtask

  // Expected entries are {piece, from, to}.
  function automatic logic [15:0] mv(input int p, input int f, input int t);
    return {4'(p), 6'(f), 6'(t)};
  endfunction

  task automatic expect_white_start();
    exp_q.delete();
    exp_q.push_back(mv(1, 1, 16)); exp_q.push_back(mv(1, 1, 18));
    exp_q.push_back(mv(1, 6, 21)); exp_q.push_back(mv(1, 6, 23));
    for (int p = 8; p < 16; p++) begin
      exp_q.push_back(mv(0, p, p + 8));
      exp_q.push_back(mv(0, p, p + 16));
    end
  endtask

  task automatic expect_black_start();
    exp_q.delete();
    for (int p = 48; p < 56; p++) begin
      exp_q.push_back(mv(6, p, p - 16));
      exp_q.push_back(mv(6, p, p - 8));
    end
    exp_q.push_back(mv(7, 57, 40)); exp_q.push_back(mv(7, 57, 42));
    exp_q.push_back(mv(7, 62, 45)); exp_q.push_back(mv(7, 62, 47));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Collects moves until the enumerator goes idle; out_ready is held low for
  // `stall` cycles on each move, and abort is pulsed once `abort_at` moves are taken.
  task automatic run(input string tag, input int stall, input int abort_at);
    int hold;
    bit fin;
    logic [15:0] cur;
    got_q.delete();
    dones = 0; cyc = 0; hold = 0; fin = 1'b0; cur = '0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (done) dones++;
      if (!busy) begin
        fin = 1'b1;
        out_ready = 1'b0;
      end else if (abort_at > 0 && got_q.size() == abort_at && !out_valid) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check({tag, "_abort_busy"}, 64'(busy), 64'd0);
        check({tag, "_abort_valid"}, 64'(out_valid), 64'd0);
        fin = 1'b1;
      end else if (out_valid) begin
        if (hold == 0) cur = {out_piece, out_from, out_to};
        else check({tag, "_stall_hold"}, 64'({out_piece, out_from, out_to}), 64'(cur));
        if (hold >= stall) begin
          out_ready = 1'b1;
          got_q.push_back({out_piece, out_from, out_to});
          hold = 0;
        end else begin
          out_ready = 1'b0;
          hold++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    check({tag, "_terminated"}, 64'(fin), 64'd1);
  endtask

  task automatic compare_moves(input string tag);
    check({tag, "_nmoves"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_mv%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; side = 1'b0; out_ready = 1'b0;
    position = '0; en_passant = '0;
    #17;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(move_count), 64'd0);
    check("rst_pos", 64'(|mv_position), 64'd0);
    check("rst_idx", 64'({mv_from_y, mv_from_x, mv_to_y, mv_to_x}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // White from the start position, no stalls.
    set_start_position(); side = 1'b1;
    pulse_start();
    run("white", 0, 0);
    expect_white_start();
    compare_moves("white");
    check("white_count", 64'(move_count), 64'd20);
    check("white_dones", 64'(dones), 64'd1);
    check("white_cycles", 64'(cyc), 64'd1109);
    check("white_promo", 64'(mv_promo), 64'd0);

    // Bare kings, white to move.
    set_kings_only(); side = 1'b1;
    pulse_start();
    run("kings", 0, 0);
    exp_q.delete();
    exp_q.push_back(mv(5, 4, 3));  exp_q.push_back(mv(5, 4, 5));
    exp_q.push_back(mv(5, 4, 11)); exp_q.push_back(mv(5, 4, 12));
    exp_q.push_back(mv(5, 4, 13));
    compare_moves("kings");
    check("kings_count", 64'(move_count), 64'd5);
    check("kings_dones", 64'(dones), 64'd1);
    check("kings_cycles", 64'(cyc), 64'd134);

    // Black from the start position.
    set_start_position(); side = 1'b0;
    pulse_start();
    run("black", 0, 0);
    expect_black_start();
    compare_moves("black");
    check("black_count", 64'(move_count), 64'd20);
    check("black_dones", 64'(dones), 64'd1);

    // Consumer stalls 7 cycles on every move.
    set_start_position(); side = 1'b1;
    pulse_start();
    run("stall", 7, 0);
    expect_white_start();
    compare_moves("stall");
    check("stall_count", 64'(move_count), 64'd20);
    check("stall_dones", 64'(dones), 64'd1);

    // Abort after the third handshake, then a fresh full run.
    pulse_start();
    run("abort", 0, 3);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_nmoves", 64'(got_q.size()), 64'd3);
    check("abort_dones", 64'(dones), 64'd0);
    check("abort_count", 64'(move_count), 64'd3);
    check("abort_idle", 64'(busy), 64'd0);
    pulse_start();
    run("rerun", 0, 0);
    compare_moves("rerun");
    check("rerun_count", 64'(move_count), 64'd20);

    // Asynchronous reset in the middle of SCAN_TO.
    pulse_start();
    repeat (30) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_count", 64'(move_count), 64'd0);
    check("mid_rst_pos", 64'(|mv_position), 64'd0);
    check("mid_rst_idx", 64'({mv_from_y, mv_from_x, mv_to_y, mv_to_x}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start and input changes while busy have no effect.
    set_start_position(); side = 1'b1;
    pulse_start();
    repeat (50) @(negedge clk);
    set_kings_only(); side = 1'b0; en_passant = 64'hFFFF_0000_0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run("busy_start", 0, 0);
    expect_white_start();
    compare_moves("busy_start");
    check("busy_start_count", 64'(move_count), 64'd20);
    check("busy_start_side", 64'(mv_side), 64'd1);
    check("busy_start_ep", mv_en_passant, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
